// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target with fixed address, byte buffer and host access port
module i2c_slave_responder #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22,
  parameter int MEM_DEPTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          scl_i,
  input  logic                          sda_i,
  output logic                          sda_o,
  input  logic                          mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
  input  logic [I2C_DATA_WIDTH-1:0]     mem_wdata,
  output logic [I2C_DATA_WIDTH-1:0]     mem_rdata,
  output logic                          rx_valid,
  output logic [I2C_DATA_WIDTH-1:0]     rx_data,
  output logic                          busy,
  output logic                          addressed
);
  localparam int DW = I2C_DATA_WIDTH;
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(DW + 1);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
  state_t state_q, state_d;
  logic scl_s1_q, scl_s2_q, scl_d_q, sda_s1_q, sda_s2_q, sda_d_q;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic sda_o_q, sda_o_d, busy_q, busy_d, addressed_q, addressed_d, rx_valid_q, rx_valid_d;
  logic [DW-1:0] rx_data_q, rx_data_d, mem_rdata_q, rd_byte;
  logic [DW-1:0] mem_q [MEM_DEPTH];
  logic start, stop, scl_rise, scl_fall, store;
  assign scl_rise = scl_s2_q & ~scl_d_q;
  assign scl_fall = ~scl_s2_q & scl_d_q;
  assign start = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
  assign stop = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;
  assign rd_byte = mem_q[ptr_q];
  always_comb begin
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    shift_d = shift_q;
    ptr_d = ptr_q;
    sda_o_d = sda_o_q;
    busy_d = busy_q;
    addressed_d = addressed_q;
    rx_valid_d = 1'b0;
    rx_data_d = rx_data_q;
    store = 1'b0;
    if (start) begin
      busy_d = 1'b1;
      addressed_d = 1'b0;
      bitcnt_d = '0;
      ptr_d = '0;
      sda_o_d = 1'b1;
      state_d = ADDR;
    end else if (stop) begin
      sda_o_d = 1'b1;
      busy_d = 1'b0;
      addressed_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[DW-2:0], sda_s2_q};
            bitcnt_d = bitcnt_q + CW'(1);
          end else if (scl_fall && bitcnt_q == CW'(I2C_ADDR_WIDTH + 1)) begin
            addressed_d = shift_q[I2C_ADDR_WIDTH:1] == SLAVE_ADDR;
            sda_o_d = shift_q[I2C_ADDR_WIDTH:1] != SLAVE_ADDR;
            state_d = shift_q[I2C_ADDR_WIDTH:1] == SLAVE_ADDR ? ADDR_ACK : WAIT_STOP;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = '0;
            shift_d = rd_byte;
            sda_o_d = shift_q[0] ? rd_byte[DW-1] : 1'b1;
            state_d = shift_q[0] ? RD_DATA : WR_DATA;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[DW-2:0], sda_s2_q};
            bitcnt_d = bitcnt_q + CW'(1);
          end else if (scl_fall && bitcnt_q == CW'(DW)) begin
            store = 1'b1;
            rx_valid_d = 1'b1;
            rx_data_d = shift_q;
            sda_o_d = 1'b0;
            state_d = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_o_d = 1'b1;
            ptr_d = ptr_q + AW'(1);
            bitcnt_d = '0;
            state_d = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            sda_o_d = bitcnt_q == CW'(DW - 1) ? 1'b1 : shift_q[DW-2];
            shift_d = shift_q << 1;
            bitcnt_d = bitcnt_q + CW'(1);
            state_d = bitcnt_q == CW'(DW - 1) ? RD_ACK : RD_DATA;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ptr_d = sda_s2_q ? ptr_q : ptr_q + AW'(1);
            bitcnt_d = CW'(DW);
            state_d = sda_s2_q ? WAIT_STOP : RD_ACK;
          end else if (scl_fall && bitcnt_q == CW'(DW)) begin
            shift_d = rd_byte;
            sda_o_d = rd_byte[DW-1];
            bitcnt_d = '0;
            state_d = RD_DATA;
          end
        end
        default: sda_o_d = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      {scl_s1_q, scl_s2_q, scl_d_q, sda_s1_q, sda_s2_q, sda_d_q} <= '1;
      state_q <= IDLE;
      bitcnt_q <= '0;
      shift_q <= '0;
      ptr_q <= '0;
      sda_o_q <= 1'b1;
      busy_q <= 1'b0;
      addressed_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      {scl_d_q, scl_s2_q, scl_s1_q} <= {scl_s2_q, scl_s1_q, scl_i};
      {sda_d_q, sda_s2_q, sda_s1_q} <= {sda_s2_q, sda_s1_q, sda_i};
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q <= shift_d;
      ptr_q <= ptr_d;
      sda_o_q <= sda_o_d;
      busy_q <= busy_d;
      addressed_q <= addressed_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q <= rx_data_d;
      mem_rdata_q <= mem_q[mem_addr];
    end
  end
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
    if (store && !rst_i) mem_q[ptr_q] <= shift_q;
  end
  assign sda_o = sda_o_q;
  assign busy = busy_q;
  assign addressed = addressed_q;
  assign rx_valid = rx_valid_q;
  assign rx_data = rx_data_q;
  assign mem_rdata = mem_rdata_q;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bus-level master with reference buffer model and scoreboard checks
module tb_i2c_slave_responder;
  localparam int Q = 6;
  localparam logic [6:0] SA = 7'h22;
  logic clk_i = 1'b0, rst_i = 1'b1, scl_m = 1'b1, sda_m = 1'b1, mem_we = 1'b0;
  logic [5:0] mem_addr = '0;
  logic [7:0] mem_wdata = '0;
  logic sda_o, rx_valid, busy, addressed, sda_bus;
  logic [7:0] mem_rdata, rx_data;
  assign sda_bus = sda_m & sda_o;
  always #5 clk_i = ~clk_i;
  i2c_slave_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .addressed(addressed)
  );
  logic [7:0] mdl [64];
  int mptr = 0;
  logic [7:0] exp_rx[$], exp_rd[$];
  logic exp_ack[$];
  int n_checks = 0, n_fail = 0;
  logic obs_ack_v = 1'b0, obs_rd_v = 1'b0, obs_ack = 1'b0;
  logic [7:0] obs_rd = '0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask
  always @(negedge clk_i)
    if (rx_valid === 1'b1) begin
      if (exp_rx.size() == 0) unexpected("rx_data", rx_data);
      else check("rx_data", rx_data, exp_rx.pop_front());
    end
  always @(posedge clk_i) begin
    if (obs_ack_v) begin
      if (exp_ack.size() == 0) unexpected("ack", obs_ack);
      else check("ack", obs_ack, exp_ack.pop_front());
    end
    if (obs_rd_v) begin
      if (exp_rd.size() == 0) unexpected("rd_data", obs_rd);
      else check("rd_data", obs_rd, exp_rd.pop_front());
    end
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic qwait(input int n);
    repeat (n * Q) @(negedge clk_i);
  endtask
  task automatic bit_io(input logic b, output logic r);
    sda_m = b;
    qwait(1);
    scl_m = 1'b1;
    qwait(1);
    r = sda_bus;
    qwait(1);
    scl_m = 1'b0;
    qwait(1);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1;
    qwait(1);
    scl_m = 1'b1;
    qwait(1);
    sda_m = 1'b0;
    qwait(1);
    scl_m = 1'b0;
    qwait(1);
    mptr = 0;
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0;
    qwait(1);
    scl_m = 1'b1;
    qwait(1);
    sda_m = 1'b1;
    qwait(2);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic ack_exp);
    logic r;
    exp_ack.push_back(ack_exp);
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    obs_ack = ~r;
    obs_ack_v = 1'b1;
    @(negedge clk_i);
    obs_ack_v = 1'b0;
  endtask
  task automatic m_addr(input logic [6:0] a, input logic rw);
    send_byte({a, rw}, a == SA);
  endtask
  task automatic m_write(input logic [7:0] b);
    exp_rx.push_back(b);
    mdl[mptr] = b;
    mptr = (mptr + 1) % 64;
    send_byte(b, 1'b1);
  endtask
  task automatic m_read(input logic nack);
    logic [7:0] v;
    logic r;
    exp_rd.push_back(mdl[mptr]);
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      v[i] = r;
    end
    bit_io(nack, r);
    if (!nack) mptr = (mptr + 1) % 64;
    obs_rd = v;
    obs_rd_v = 1'b1;
    @(negedge clk_i);
    obs_rd_v = 1'b0;
  endtask
  task automatic host_write(input int a, input logic [7:0] d);
    mem_we = 1'b1;
    mem_addr = 6'(a);
    mem_wdata = d;
    @(negedge clk_i);
    mem_we = 1'b0;
    mdl[a] = d;
  endtask
  task automatic host_check(input int a);
    mem_addr = 6'(a);
    @(negedge clk_i);
    check($sformatf("host_rd[%0d]", a), mem_rdata, mdl[a]);
  endtask
  initial begin
    logic r;
    logic [6:0] ba;
    repeat (3) @(negedge clk_i);
    check("rst_sda_o", sda_o, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_addressed", addressed, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_mem_rdata", mem_rdata, 8'h00);
    rst_i = 1'b0;
    qwait(2);
    i2c_start();
    check("t1_busy", busy, 1'b1);
    m_addr(SA, 1'b0);
    check("t1_addressed", addressed, 1'b1);
    for (int i = 0; i < 32; i++) m_write(8'(i));
    i2c_stop();
    check("t1_busy_after_stop", busy, 1'b0);
    check("t1_addressed_after_stop", addressed, 1'b0);
    for (int i = 0; i < 32; i += 7) host_check(i);
    for (int i = 0; i < 32; i++) host_write(i, 8'(100 + i));
    i2c_start();
    m_addr(SA, 1'b1);
    for (int i = 0; i < 32; i++) m_read(i == 31);
    check("t2_sda_released", sda_o, 1'b1);
    i2c_stop();
    check("t2_busy_after_stop", busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ba = 7'($urandom_range(0, 127));
      if (ba == SA) ba = ba ^ 7'h01;
      i2c_start();
      send_byte({ba, 1'($urandom)}, 1'b0);
      check("t3_addressed", addressed, 1'b0);
      check("t3_sda_o", sda_o, 1'b1);
      send_byte(8'($urandom), 1'b0);
      check("t3_busy", busy, 1'b1);
      i2c_stop();
      check("t3_busy_after_stop", busy, 1'b0);
    end
    i2c_start();
    m_addr(SA, 1'b0);
    m_write(8'h05);
    i2c_start();
    m_addr(SA, 1'b1);
    m_read(1'b1);
    check("t4_addressed", addressed, 1'b1);
    i2c_stop();
    i2c_start();
    m_addr(SA, 1'b0);
    for (int i = 0; i < 66; i++) m_write(8'($urandom));
    i2c_stop();
    host_check(0);
    host_check(1);
    host_check(63);
    host_write(0, 8'($urandom) & 8'hEF);
    i2c_start();
    m_addr(SA, 1'b1);
    for (int i = 0; i < 3; i++) bit_io(1'b1, r);
    sda_m = 1'b1;
    qwait(1);
    scl_m = 1'b1;
    qwait(1);
    check("t6_sda_driven", sda_o, 1'b0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("t6_sda_after_rst", sda_o, 1'b1);
    check("t6_busy_after_rst", busy, 1'b0);
    check("t6_addressed_after_rst", addressed, 1'b0);
    qwait(1);
    scl_m = 1'b0;
    qwait(1);
    i2c_stop();
    for (int i = 0; i < 8; i++) host_write(i, 8'($urandom));
    i2c_start();
    m_addr(SA, 1'b1);
    for (int i = 0; i < 8; i++) m_read(i == 7);
    i2c_stop();
    check("t6_busy_after_stop", busy, 1'b0);
    for (int i = 0; i < 64; i++) host_check(i);
    for (int i = 0; i < 100 && (exp_rx.size() + exp_rd.size() + exp_ack.size()) != 0; i++) @(negedge clk_i);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("ack_queue_drained", exp_ack.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
